seq_detector_param: RTL

Parametrised serial bit-pattern detector: the generalised successor of the team's fixed 5-bit overlapping Mealy detectors. Pattern, pattern length (1..PAT_W) and overlap mode are runtime-programmable. Input bits are qualified by a valid strobe. A registered one-cycle match pulse and an optional saturating match counter are produced. The block sits between a serial bit source and control/status logic.

---
 rtl/seq_detector_param.sv | 134 +++++++++++++
 1 files changed

// File: rtl/seq_detector_param.sv
// seq_detector_param
// Serial bit-pattern detector with runtime-programmable pattern, length
// (1..PAT_W) and overlap mode. Input bits are qualified by din_valid. The
// block produces a registered one-cycle match pulse and an optional
// saturating match counter.
//
// Optional feature macro: SEQ_DET_COUNT_EN
//   defined   : match counter flops present, match_count = saturating count
//   undefined : no counter flops, match_count tied to zero
//
// Ports
//   clk          in   1      rising-edge clock
//   reset_n      in   1      asynchronous active-low reset
//   din          in   1      serial data bit
//   din_valid    in   1      din is sampled only when high
//   cfg_load     in   1      strobe latching cfg_pattern/cfg_len/cfg_overlap
//   cfg_pattern  in   PAT_W  pattern; bit [len-1] arrives first, bit [0] last
//   cfg_len      in   LEN_W  pattern length (valid range 1..PAT_W)
//   cfg_overlap  in   1      1 = overlapping, 0 = non-overlapping detection
//   seq_detected out  1      registered one-cycle match pulse
//   match_count  out  CNT_W  saturating match count
module seq_detector_param #(
   parameter int               PAT_W       = 8,
   parameter int               CNT_W       = 16,
   parameter logic [PAT_W-1:0] DEF_PATTERN = PAT_W'(8'b0001_0101),
   parameter int               DEF_LEN     = 5,
   parameter int               LEN_W       = $clog2(PAT_W + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             din,
   input  logic             din_valid,
   input  logic             cfg_load,
   input  logic [PAT_W-1:0] cfg_pattern,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic             cfg_overlap,
   output logic             seq_detected,
   output logic [CNT_W-1:0] match_count
);

   typedef enum logic {
      CFG_INVALID = 1'b0,
      RUN         = 1'b1
   } state_e;

   localparam logic [LEN_W-1:0] PAT_W_L   = LEN_W'(PAT_W);
   localparam logic [LEN_W-1:0] DEF_LEN_L = LEN_W'(DEF_LEN);
   localparam state_e RST_STATE =
      ((DEF_LEN >= 1) && (DEF_LEN <= PAT_W)) ? RUN : CFG_INVALID;

   state_e             state_q;
   logic [PAT_W-1:0]   pat_q;
   logic [LEN_W-1:0]   len_q;
   logic               ovl_q;
   logic [PAT_W-1:0]   hist_q;
   logic [LEN_W-1:0]   fill_q;
   logic               det_q;

   logic [PAT_W-1:0]   hist_d;
   logic [LEN_W-1:0]   fill_d;
   logic [PAT_W-1:0]   len_mask;
   logic               hit;
   logic               cfg_valid;

`ifdef SEQ_DET_COUNT_EN
   logic [CNT_W-1:0]   cnt_q;
`endif

   // Config validity is resolved at load time so the compare path only
   // has to look at the registered state.
   assign cfg_valid = (cfg_len != '0) && (cfg_len <= PAT_W_L);

   always_comb begin
      hist_d = {hist_q[PAT_W-2:0], din};
      fill_d = (fill_q >= PAT_W_L) ? PAT_W_L : fill_q + 1'b1;

      // Only the low len_q bits take part in the compare.
      len_mask = '0;
      for (int unsigned i = 0; i < PAT_W; i++) begin
         len_mask[i] = (i < 32'(len_q));
      end

      hit = 1'b0;
      if (din_valid && !cfg_load && (state_q == RUN) && (fill_d >= len_q)) begin
         hit = (((hist_d ^ pat_q) & len_mask) == '0);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= RST_STATE;
         pat_q   <= DEF_PATTERN;
         len_q   <= DEF_LEN_L;
         ovl_q   <= 1'b1;
         hist_q  <= '0;
         fill_q  <= '0;
         det_q   <= 1'b0;
`ifdef SEQ_DET_COUNT_EN
         cnt_q   <= '0;
`endif
      end else if (cfg_load) begin
         // Load wins over any din sampled in the same cycle.
         state_q <= cfg_valid ? RUN : CFG_INVALID;
         pat_q   <= cfg_pattern;
         len_q   <= cfg_len;
         ovl_q   <= cfg_overlap;
         hist_q  <= '0;
         fill_q  <= '0;
         det_q   <= 1'b0;
      end else if (din_valid) begin
         hist_q <= hist_d;
         // Non-overlapping mode restarts the fill count after a match, so
         // stale history bits can never contribute to the next match.
         fill_q <= (hit && !ovl_q) ? '0 : fill_d;
         det_q  <= hit;
`ifdef SEQ_DET_COUNT_EN
         if (hit && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
         end
`endif
      end else begin
         det_q <= 1'b0;
      end
   end

   assign seq_detected = det_q;

`ifdef SEQ_DET_COUNT_EN
   assign match_count = cnt_q;
`else
   assign match_count = '0;
`endif

endmodule
